// File: rtl/alu_pkg.sv
// Shared opcode map, status bit positions and FSM encoding for the accumulator bank.
package alu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_ZERO   = 4'h4;
  localparam logic [3:0] OP_ONE    = 4'h5;
  localparam logic [3:0] OP_XOR    = 4'h6;
  localparam logic [3:0] OP_NOT    = 4'h7;
  localparam logic [3:0] OP_SHL    = 4'h8;
  localparam logic [3:0] OP_SHR    = 4'h9;
  localparam logic [3:0] OP_AND    = 4'hA;
  localparam logic [3:0] OP_OR     = 4'hB;
  localparam logic [3:0] OP_MUL    = 4'hC;
  localparam logic [3:0] OP_DIV    = 4'hD;
  localparam logic [3:0] OP_MOD    = 4'hE;
  localparam logic [3:0] OP_STATUS = 4'hF;

  localparam int unsigned ST_Z  = 0;
  localparam int unsigned ST_N  = 1;
  localparam int unsigned ST_C  = 2;
  localparam int unsigned ST_DZ = 3;

  typedef enum logic {S_IDLE, S_ITER} state_e;

  function automatic logic [3:0] mk_status(input logic z, input logic n,
                                           input logic c, input logic dz);
    mk_status        = '0;
    mk_status[ST_Z]  = z;
    mk_status[ST_N]  = n;
    mk_status[ST_C]  = c;
    mk_status[ST_DZ] = dz;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one hi/lo register pair.
module alu_muldiv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             mode_q, mode_d, run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum, r_shift, trial;
  logic             ge;
  logic [WIDTH-1:0] hi_step, lo_step;

  // mode 0: hi accumulates partial product, lo holds multiplier.
  // mode 1: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    r_shift = {hi_q, lo_q[WIDTH-1]};
    trial   = r_shift - {1'b0, b_q};
    ge      = (r_shift >= {1'b0, b_q});
    if (mode_q) begin
      hi_step = ge ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    mode_d = mode_q;
    run_d  = run_q;
    cnt_d  = cnt_q;
    if (start) begin
      hi_d   = '0;
      lo_d   = a;
      b_d    = b;
      mode_d = mode;
      run_d  = 1'b1;
      cnt_d  = CW'(WIDTH - 1);
    end else if (run_q) begin
      hi_d = hi_step;
      lo_d = lo_step;
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      run_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      run_q  <= run_d;
      cnt_q  <= cnt_d;
    end
  end

  // Results are the outcome of the step in flight, so the owner can write back
  // on the same edge as the final iteration.
  assign product_lo = lo_step;
  assign product_hi = hi_step;
  assign quotient   = lo_step;
  assign remainder  = hi_step;
  assign done       = run_q && (cnt_q == '0);

endmodule

// File: rtl/alu_bank.sv
// Bank of NUM_ACC accumulators with per-accumulator status and a valid/ready op port.
module alu_bank
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_ACC = 4,
  localparam int unsigned ACC_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [ACC_W-1:0] acc_sel,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] WIDTH_D = WIDTH'(WIDTH);

  logic [WIDTH-1:0] acc_q [NUM_ACC];
  logic [WIDTH-1:0] acc_d [NUM_ACC];
  logic [3:0]       st_q  [NUM_ACC];
  logic [3:0]       st_d  [NUM_ACC];

  state_e           state_q, state_d;
  logic [ACC_W-1:0] sel_q, sel_d;
  logic             show_st_q, show_st_d;
  logic [3:0]       iop_q, iop_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_op, alu_res, wr_res;
  logic             alu_c, wr_en, wr_c, wr_dz, md_start, md_done;
  logic [WIDTH-1:0] md_plo, md_phi, md_quo, md_rem;

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (md_start),
    .mode       (opcode != OP_MUL),
    .a          (a_op),
    .b          (data_in),
    .product_lo (md_plo),
    .product_hi (md_phi),
    .quotient   (md_quo),
    .remainder  (md_rem),
    .done       (md_done)
  );

  always_comb begin
    a_op    = acc_q[acc_sel];
    alu_res = '0;
    alu_c   = 1'b0;
    case (opcode)
      OP_LOAD: alu_res = data_in;
      OP_ADD:  {alu_c, alu_res} = {1'b0, a_op} + {1'b0, data_in};
      OP_SUB:  {alu_c, alu_res} = {1'b0, a_op} - {1'b0, data_in};
      OP_ONE:  alu_res = WIDTH'(1);
      OP_XOR:  alu_res = a_op ^ data_in;
      OP_NOT:  alu_res = ~a_op;
      OP_AND:  alu_res = a_op & data_in;
      OP_OR:   alu_res = a_op | data_in;
      // One guard bit catches the last bit shifted out; beyond WIDTH it is lost.
      OP_SHL:  if (data_in <= WIDTH_D) {alu_c, alu_res} = {1'b0, a_op} << data_in;
      OP_SHR:  if (data_in <= WIDTH_D) {alu_res, alu_c} = {a_op, 1'b0} >> data_in;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    show_st_d = show_st_q;
    iop_d     = iop_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    st_d      = st_q;
    md_start  = 1'b0;
    wr_en     = 1'b0;
    wr_res    = '0;
    wr_c      = 1'b0;
    wr_dz     = 1'b0;
    case (state_q)
      S_IDLE: if (op_valid) begin
        sel_d     = acc_sel;
        show_st_d = (opcode == OP_STATUS);
        case (opcode)
          OP_MUL, OP_DIV, OP_MOD: begin
            md_start = 1'b1;
            iop_d    = opcode;
            dz_d     = (data_in == '0);
            state_d  = S_ITER;
          end
          OP_NOP, OP_STATUS: ;
          default: begin
            wr_en  = 1'b1;
            wr_res = alu_res;
            wr_c   = alu_c;
          end
        endcase
      end
      S_ITER: if (md_done) begin
        wr_en   = 1'b1;
        state_d = S_IDLE;
        wr_dz   = dz_q && (iop_q != OP_MUL);
        case (iop_q)
          OP_MUL:  begin wr_res = md_plo; wr_c = |md_phi; end
          OP_DIV:  begin wr_res = md_quo; wr_c = |md_rem; end
          default: begin wr_res = md_rem; wr_c = |md_quo; end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_en) begin
      done_d       = 1'b1;
      acc_d[sel_d] = wr_res;
      st_d[sel_d]  = mk_status(wr_res == '0, wr_res[WIDTH-1], wr_c, wr_dz);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ACC; i++) begin
        acc_q[i] <= '0;
        st_q[i]  <= '0;
      end
      state_q   <= S_IDLE;
      sel_q     <= '0;
      show_st_q <= 1'b0;
      iop_q     <= OP_NOP;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      st_q      <= st_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
      show_st_q <= show_st_d;
      iop_q     <= iop_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign op_ready = (state_q == S_IDLE);
  assign busy     = ~op_ready;
  assign done     = done_q;
  assign data_out = show_st_q ? WIDTH'(st_q[sel_q]) : acc_q[sel_q];

endmodule

// File: tb/tb_alu_bank.sv
// Directed bench for alu_bank: an 8-bit/4-accumulator and a 16-bit/1-accumulator instance.
module tb_alu_bank;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a, va, ra, ba, donea;
  logic [3:0] opa;
  logic [1:0] sela;
  logic [7:0] dia, doa;

  logic        rstn_b, vb, rb, bb, doneb;
  logic [3:0]  opb;
  logic [0:0]  selb;
  logic [15:0] dib, dob;

  int n_cmp = 0;
  int n_mis = 0;

  alu_bank #(.WIDTH(8), .NUM_ACC(4)) u_a (
    .clk(clk), .rst_n(rstn_a), .op_valid(va), .op_ready(ra), .opcode(opa),
    .acc_sel(sela), .data_in(dia), .data_out(doa), .done(donea), .busy(ba)
  );

  alu_bank #(.WIDTH(16), .NUM_ACC(1)) u_b (
    .clk(clk), .rst_n(rstn_b), .op_valid(vb), .op_ready(rb), .opcode(opb),
    .acc_sel(selb), .data_in(dib), .data_out(dob), .done(doneb), .busy(bb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one op for a single accept edge; returns at the negedge after it.
  task automatic issue_a(input logic [3:0] o, input logic [1:0] s, input logic [7:0] d);
    @(negedge clk);
    va = 1'b1; opa = o; sela = s; dia = d;
    @(posedge clk);
    @(negedge clk);
    va = 1'b0;
  endtask

  task automatic issue_b(input logic [3:0] o, input logic [15:0] d);
    @(negedge clk);
    vb = 1'b1; opb = o; selb = 1'b0; dib = d;
    @(posedge clk);
    @(negedge clk);
    vb = 1'b0;
  endtask

  task automatic status_a(input string tag, input logic [1:0] s, input logic [7:0] exp_st);
    issue_a(OP_STATUS, s, 8'h00);
    check({tag, "_st"}, doa, exp_st);
    check({tag, "_st_nodone"}, donea, 1'b0);
  endtask

  task automatic single_a(input string tag, input logic [3:0] o, input logic [1:0] s,
                          input logic [7:0] d, input logic [7:0] exp, input logic [7:0] exp_st);
    issue_a(o, s, d);
    check({tag, "_done"}, donea, 1'b1);
    check({tag, "_rdy"}, ra, 1'b1);
    check({tag, "_out"}, doa, exp);
    status_a(tag, s, exp_st);
  endtask

  task automatic iter_a(input string tag, input logic [3:0] o, input logic [1:0] s,
                        input logic [7:0] d, input logic [7:0] exp, input logic [7:0] exp_st);
    int n;
    issue_a(o, s, d);
    check({tag, "_busy"}, ba, 1'b1);
    n = 0;
    while (!ra && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, n, 8);
    check({tag, "_done"}, donea, 1'b1);
    check({tag, "_out"}, doa, exp);
    status_a(tag, s, exp_st);
  endtask

  task automatic iter_b(input string tag, input logic [3:0] o, input logic [15:0] d,
                        input logic [15:0] exp, input logic [15:0] exp_st);
    int n;
    issue_b(o, d);
    n = 0;
    while (!rb && n < 60) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, n, 16);
    check({tag, "_done"}, doneb, 1'b1);
    check({tag, "_out"}, dob, exp);
    issue_b(OP_STATUS, 16'h0000);
    check({tag, "_st"}, dob, exp_st);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_a = 1'b0; va = 1'b0; opa = '0; sela = '0; dia = '0;
    rstn_b = 1'b0; vb = 1'b0; opb = '0; selb = '0; dib = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy", ra, 1'b1);
    check("rst_busy", ba, 1'b0);
    check("rst_out", doa, 8'h00);
    check("rst_done", donea, 1'b0);
    check("rst_b_rdy", rb, 1'b1);
    check("rst_b_out", dob, 16'h0000);
    rstn_a = 1'b1;
    rstn_b = 1'b1;

    // Single-cycle ops, instance A
    single_a("load1", OP_LOAD, 2'd1, 8'hF0, 8'hF0, 8'h02);
    single_a("add1",  OP_ADD,  2'd1, 8'h20, 8'h10, 8'h04);
    single_a("load2", OP_LOAD, 2'd2, 8'h10, 8'h10, 8'h00);
    iter_a("mul2", OP_MUL, 2'd2, 8'h11, 8'h10, 8'h04);
    single_a("sub2", OP_SUB, 2'd2, 8'h20, 8'hF0, 8'h06);
    check("acc1_untouched", u_a.acc_q[1], 8'h10);

    single_a("load0", OP_LOAD, 2'd0, 8'h64, 8'h64, 8'h00);
    iter_a("div0", OP_DIV, 2'd0, 8'h07, 8'h0E, 8'h04);
    single_a("reload0", OP_LOAD, 2'd0, 8'h64, 8'h64, 8'h00);
    iter_a("mod0", OP_MOD, 2'd0, 8'h07, 8'h02, 8'h04);

    single_a("load3", OP_LOAD, 2'd3, 8'h55, 8'h55, 8'h00);
    iter_a("divz3", OP_DIV, 2'd3, 8'h00, 8'hFF, 8'h0E);
    single_a("clrdz3", OP_LOAD, 2'd3, 8'h00, 8'h00, 8'h01);

    single_a("ld81a", OP_LOAD, 2'd1, 8'h81, 8'h81, 8'h02);
    single_a("shl1",  OP_SHL,  2'd1, 8'h01, 8'h02, 8'h04);
    single_a("ld81b", OP_LOAD, 2'd1, 8'h81, 8'h81, 8'h02);
    single_a("shl9",  OP_SHL,  2'd1, 8'h09, 8'h00, 8'h01);
    single_a("ld81c", OP_LOAD, 2'd1, 8'h81, 8'h81, 8'h02);
    single_a("shl8",  OP_SHL,  2'd1, 8'h08, 8'h00, 8'h05);
    single_a("ld81d", OP_LOAD, 2'd1, 8'h81, 8'h81, 8'h02);
    single_a("shr1",  OP_SHR,  2'd1, 8'h01, 8'h40, 8'h04);
    single_a("shr0",  OP_SHR,  2'd1, 8'h00, 8'h40, 8'h00);

    // Reset in the middle of a divide, instance A
    issue_a(OP_LOAD, 2'd0, 8'h64);
    issue_a(OP_DIV, 2'd0, 8'h07);
    repeat (3) @(negedge clk);
    #2 rstn_a = 1'b0;
    #1;
    check("abort_rdy", ra, 1'b1);
    check("abort_busy", ba, 1'b0);
    check("abort_out", doa, 8'h00);
    check("abort_done", donea, 1'b0);
    @(negedge clk);
    rstn_a = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      issue_a(OP_NOP, k[1:0], 8'h00);
      check($sformatf("abort_acc%0d", k), doa, 8'h00);
      check($sformatf("abort_nodone%0d", k), donea, 1'b0);
    end

    // Instance B: WIDTH=16, NUM_ACC=1
    issue_b(OP_LOAD, 16'h1234);
    check("b_load", dob, 16'h1234);
    iter_b("b_div", OP_DIV, 16'h0010, 16'h0123, 16'h0004);
    iter_b("b_mul", OP_MUL, 16'h0100, 16'h2300, 16'h0004);
    issue_b(OP_LOAD, 16'h00FF);
    issue_b(OP_DIV, 16'h0003);
    repeat (5) @(negedge clk);
    #2 rstn_b = 1'b0;
    #1;
    check("b_abort_rdy", rb, 1'b1);
    check("b_abort_busy", bb, 1'b0);
    check("b_abort_out", dob, 16'h0000);
    check("b_abort_done", doneb, 1'b0);
    @(negedge clk);
    rstn_b = 1'b1;
    issue_b(OP_NOP, 16'h0000);
    check("b_abort_acc0", dob, 16'h0000);
    check("b_abort_nodone", doneb, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_bank.md
# alu_bank

Parametrised, multi-accumulator successor to the byte ALU. Holds NUM_ACC accumulators of WIDTH bits, each with its own 4-bit status. Executes one opcode per valid/ready handshake. Single-cycle ops complete at the accept edge; multiply, divide and modulo run on a shared iterative unit for WIDTH cycles, and the block back-pressures the issuer while they run. Sits between the user-IO decode and the output mux, with the same opcode map and data_out status/accumulator selection as the byte ALU.

## Interface
- WIDTH, 8, datapath width; at least 4.
- NUM_ACC, 4, accumulator count; a power of two, at least 1. ACC_W = max(1, clog2(NUM_ACC)).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- op_valid  in  1  issuer presents an op.
- op_ready  out  1  block can accept; high exactly when the FSM is IDLE.
- opcode  in  4  operation code, see Operation.
- acc_sel  in  ACC_W  target accumulator.
- data_in  in  WIDTH  operand.
- data_out  out  WIDTH  selected accumulator, or zero-extended status after opcode F.
- done  out  1  one-cycle pulse after an op's result is written.
- busy  out  1  iterative op in progress; always the inverse of op_ready.

## Operation
- Accept happens when op_valid and op_ready are both high at a rising edge. opcode, acc_sel and data_in are sampled only at the accept edge and latched for the op.
- Opcodes, with A = acc[acc_sel] and D = data_in:
  - 0 nop
  - 1 load: A=D
  - 2 add
  - 3 sub
  - 4 zero: A=0
  - 5 one: A=1
  - 6 xor
  - 7 not: A=~A
  - 8 shl: A<<D
  - 9 shr: A>>D
  - A and
  - B or
  - C mul
  - D div
  - E mod
  - F status: no write
- Status bits per accumulator: [0] Z (result==0), [1] N (result MSB), [2] C, [3] DZ.
- Every writing op updates Z, N and C. DZ is set only by div or mod with D==0 and is cleared by every other writing op. nop and status leave status unchanged.
- C rules:
  - add: carry out.
  - sub: borrow (D>A).
  - shl/shr: last bit shifted out. C=0 when D==0. C=0 when D>WIDTH. When D>=WIDTH the result is 0.
  - mul: unsigned product, low WIDTH bits kept; C=1 when the high half is nonzero.
  - div: C = (remainder!=0).
  - mod: C = (quotient!=0).
  - load, zero, one, logic ops: C=0.
- Divide by zero: the iterative unit runs normally and yields quotient all-ones and remainder A. DZ=1.
- data_out:
  - After an accepted opcode F it shows {0, status[acc_sel]}.
  - After any other accepted op it shows acc[last acc_sel].
  - It holds between accepts. It tracks writes to the shown accumulator.
- FSM states:
  - IDLE: accept C/D/E, go to ITER.
  - ITER: count WIDTH-1 down to 0; at count 0, write result and status, go to IDLE.

## Timing
- Single-cycle op accepted at edge E: accumulator and status are written at E. done is high during the cycle after E. op_ready stays high, so back-to-back accepts are allowed every edge.
- mul/div/mod accepted at E:
  - op_ready and busy change on the cycle after E.
  - Iterations occur at edges E+1..E+WIDTH. The result is written at E+WIDTH.
  - done is high, and op_ready high again, in the cycle after E+WIDTH.
  - The next accept is possible at E+WIDTH+1.
- While busy, op_valid is ignored and no inputs are sampled. Other accumulators are not touched.
- Reset values: all accumulators 0, all status 0, data_out 0, done 0, busy 0, op_ready 1, FSM IDLE, last acc_sel 0.
- Reset asserted mid-ITER aborts immediately. No write, no done.
- An op targeting the accumulator currently shown on data_out updates data_out in the cycle after its write edge.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_NOP..OP_STATUS)
  - status bit indices (ST_Z, ST_N, ST_C, ST_DZ)
  - FSM state encoding
- Sub-module alu_muldiv:
  - Shift-add multiplier plus restoring divider, parametrised by WIDTH.
  - Signals: start, mode, a, b in; product_lo, product_hi, quotient, remainder out; done pulse.
  - The top FSM owns the handshake and write-back.

## Test plan
- WIDTH=8, NUM_ACC=4: load acc1=0xF0, then add acc1 D=0x20. Require acc1=0x10, status=0b0100, done pulse, op_ready never low.
- mul acc2 (A=0x10) by D=0x11. Require op_ready low for 8 cycles and acc2=0x10. Require C=1 (high half 0x01).
- div acc0 (A=0x64) by D=0x07. Require acc0=0x0E and C=1. Then mod the original value by 7. Require 0x02 with C=1.
- div by D=0. Require quotient 0xFF and DZ=1. Then a load clears DZ.
- shl A=0x81 with D=1, then with D=9. Require 0x02 with C=1, then 0x00 with C=0. Opcode F then shows status on data_out.
- Assert rst_n mid-divide. Require immediate op_ready=1, all accumulators 0, no done. Repeat at WIDTH=16, NUM_ACC=1.
